// File: rtl/data_mem_responder.sv
// data_mem_responder: single-port data memory answering CPU load/store requests
// with byte/halfword/word access, sign/zero extension and error detection.
// Optional wait states are enabled by defining MEM_WAIT_EN (count = WAIT_CYCLES).
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

`ifdef MEM_WAIT_EN
  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
  logic [CNT_W-1:0] cnt_q, cnt_next;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd2} state_t;
`endif

  state_t state_q, state_next;

  logic [31:0] mem [DEPTH_WORDS];

  logic        wr_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        accept_c;
  logic        act_wr_c;
  logic [1:0]  act_size_c;
  logic        act_uns_c;
  logic [31:0] act_addr_c;
  logic        act_err_c;
  logic [IDX_W-1:0] idx_c;
  logic [31:0] rd_word_c;
  logic [7:0]  rd_byte_c;
  logic [15:0] rd_half_c;
  logic [31:0] load_data_c;
  logic [3:0]  wr_be_c;
  logic [31:0] wr_lane_c;
  logic        commit_c;

  // Request view: live inputs while idle (response computed on the accept edge), captured fields otherwise
  always_comb begin
    act_wr_c   = wr_q;
    act_size_c = size_q;
    act_uns_c  = uns_q;
    act_addr_c = addr_q;
    if (state_q == IDLE) begin
      act_wr_c   = req_write;
      act_size_c = req_size;
      act_uns_c  = req_unsigned;
      act_addr_c = req_addr;
    end
  end

  // Error classification: illegal size, misalignment, out-of-range word index
  always_comb begin
    act_err_c = 1'b0;
    if (act_size_c == 2'b11) act_err_c = 1'b1;
    if ((act_size_c == 2'b01) && act_addr_c[0]) act_err_c = 1'b1;
    if ((act_size_c == 2'b10) && (act_addr_c[1:0] != 2'b00)) act_err_c = 1'b1;
    if (32'(act_addr_c[31:2]) >= DEPTH_WORDS) act_err_c = 1'b1;
  end

  // Load path: lane extraction and sign/zero extension
  always_comb begin
    idx_c       = act_addr_c[IDX_W+1:2];
    rd_word_c   = mem[idx_c];
    rd_byte_c   = rd_word_c[{act_addr_c[1:0], 3'b000} +: 8];
    rd_half_c   = rd_word_c[{act_addr_c[1], 4'b0000} +: 16];
    load_data_c = rd_word_c;
    case (act_size_c)
      2'b00:   load_data_c = act_uns_c ? {24'd0, rd_byte_c} : {{24{rd_byte_c[7]}}, rd_byte_c};
      2'b01:   load_data_c = act_uns_c ? {16'd0, rd_half_c} : {{16{rd_half_c[15]}}, rd_half_c};
      default: load_data_c = rd_word_c;
    endcase
  end

  // Store path: byte enables and lane-replicated write data from the captured request
  always_comb begin
    wr_be_c   = 4'b0000;
    wr_lane_c = 32'd0;
    case (size_q)
      2'b00: begin
        wr_be_c   = 4'b0001 << addr_q[1:0];
        wr_lane_c = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        wr_be_c   = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_lane_c = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        wr_be_c   = 4'b1111;
        wr_lane_c = wdata_q;
      end
      default: begin
        wr_be_c   = 4'b0000;
        wr_lane_c = 32'd0;
      end
    endcase
    commit_c = rst_n && (state_q == RESP) && wr_q && !act_err_c;
  end

  // Next-state logic
  always_comb begin
    state_next = state_q;
    accept_c   = 1'b0;
`ifdef MEM_WAIT_EN
    cnt_next   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept_c = 1'b1;
`ifdef MEM_WAIT_EN
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_W'(WAIT_CYCLES);
          end
`else
          state_next = RESP;
`endif
        end
      end
`ifdef MEM_WAIT_EN
      WAIT: begin
        cnt_next = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_next = RESP;
      end
`endif
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, capture and registered response outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
`ifdef MEM_WAIT_EN
      cnt_q      <= '0;
`endif
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= 32'd0;
      wr_q       <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
    end else begin
      state_q    <= state_next;
`ifdef MEM_WAIT_EN
      cnt_q      <= cnt_next;
`endif
      req_ready  <= (state_next == IDLE);
      resp_valid <= (state_next == RESP);
      resp_error <= (state_next == RESP) && act_err_c;
      resp_rdata <= ((state_next == RESP) && !act_err_c && !act_wr_c) ? load_data_c : 32'd0;
      if (accept_c) begin
        wr_q    <= req_write;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // Storage: commit on the edge leaving RESP; contents survive reset
  always_ff @(posedge clk) begin
    if (commit_c) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be_c[b]) mem[addr_q[IDX_W+1:2]][8*b +: 8] <= wr_lane_c[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed and randomized checks of data_mem_responder
// against a byte-array reference model.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned WAITS = 2;
`ifdef MEM_WAIT_EN
  localparam int unsigned LAT = WAITS + 1;
`else
  localparam int unsigned LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  int checks = 0;
  int failures = 0;

  logic [7:0] model_mem [DEPTH*4];

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed little-endian memory with arithmetic extension
  function automatic void model(input logic wr, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic err, output logic [31:0] rdata);
    int unsigned nb;
    longint v;
    err = (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) ||
          (size == 2'd2 && (addr % 4) != 0) || ((addr / 4) >= DEPTH);
    rdata = 32'd0;
    if (err) return;
    nb = 1 << size;
    if (wr) begin
      for (int i = 0; i < int'(nb); i++) model_mem[addr + i] = 8'(wdata >> (8 * i));
    end else begin
      v = 0;
      for (int i = 0; i < int'(nb); i++) v = v + (longint'(model_mem[addr + i]) << (8 * i));
      if (!uns && nb < 4 && ((v >> (8 * nb - 1)) & 1) == 1) v = v - (longint'(1) << (8 * nb));
      rdata = 32'(v);
    end
  endfunction

  task automatic drive_garbage();
    req_write    = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
  endtask

  // One transaction: called and returns just after a falling edge
  task automatic do_req(input string tag, input logic wr, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] got_rd, output logic got_err);
    logic        exp_err;
    logic [31:0] exp_rd;
    int          n;
    int          lat;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ":ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    model(wr, size, uns, addr, wdata, exp_err, exp_rd);
    @(negedge clk);
    for (lat = 1; lat <= 20; lat++) begin
      if (resp_valid) break;
      chk({tag, ":busy_rdata"}, resp_rdata, 32'd0);
      chk({tag, ":busy_ready"}, 32'(req_ready), 32'd0);
      req_valid = 1'b1;
      drive_garbage();
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk({tag, ":latency"}, 32'(lat), 32'(LAT));
    chk({tag, ":ready_in_resp"}, 32'(req_ready), 32'd0);
    chk({tag, ":error"}, 32'(resp_error), 32'(exp_err));
    chk({tag, ":rdata"}, resp_rdata, exp_rd);
    got_rd = resp_rdata;
    got_err = resp_error;
    @(negedge clk);
    chk({tag, ":pulse_end"}, {29'd0, resp_valid, resp_error, req_ready}, 32'd1);
    chk({tag, ":rdata_idle"}, resp_rdata, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] addr;
    logic [1:0]  size;
    rst_n = 1'b0; req_valid = 1'b0;
    req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {29'd0, resp_valid, resp_error, req_ready}, 32'd1);
    chk("reset_rdata", resp_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", 32'(req_ready), 32'd1);

    // Fill every word so all later loads compare against known contents
    for (int w = 0; w < int'(DEPTH); w++)
      do_req("fill", 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, rd, er);

    do_req("w_store", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, er);
    do_req("w_load", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er);
    chk("vec_word", rd, 32'hDEADBEEF);
    do_req("b_signed", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, rd, er);
    chk("vec_byte_s", rd, 32'hFFFFFFDE);
    do_req("b_unsigned", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, rd, er);
    chk("vec_byte_u", rd, 32'h000000DE);
    do_req("h_signed", 1'b0, 2'd1, 1'b0, 32'h10, 32'h0, rd, er);
    chk("vec_half_s", rd, 32'hFFFFBEEF);
    do_req("h_upper_u", 1'b0, 2'd1, 1'b1, 32'h12, 32'h0, rd, er);
    chk("vec_half_upper", rd, 32'h0000DEAD);
    do_req("b_store", 1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFF55, rd, er);
    do_req("b_store_chk", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er);
    chk("vec_byte_store", rd, 32'hDEAD55EF);

    do_req("err_misalign", 1'b0, 2'd2, 1'b0, 32'h12, 32'h0, rd, er);
    chk("vec_err_misalign", {31'd0, er}, 32'd1);
    do_req("err_size3", 1'b1, 2'd3, 1'b0, 32'h10, 32'h11111111, rd, er);
    chk("vec_err_size3", {31'd0, er}, 32'd1);
    do_req("err_range", 1'b1, 2'd2, 1'b0, 32'h400, 32'h22222222, rd, er);
    chk("vec_err_range", {31'd0, er}, 32'd1);
    do_req("err_h_odd", 1'b1, 2'd1, 1'b0, 32'h11, 32'h3333, rd, er);
    do_req("err_unchanged", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er);
    chk("vec_mem_unchanged", rd, 32'hDEAD55EF);

    // Reset during an in-flight store aborts it
    do_req("prior", 1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D, rd, er);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
`ifdef MEM_WAIT_EN
    chk("abort_in_wait", 32'(resp_valid), 32'd0);
`endif
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_outputs", {29'd0, resp_valid, resp_error, req_ready}, 32'd1);
    chk("abort_rdata", resp_rdata, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_resp", 32'(resp_valid), 32'd0);
    end
    do_req("abort_load", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er);
    chk("vec_abort_kept", rd, 32'hCAFEF00D);

    // Randomized mix of loads, stores, misaligned, illegal and out-of-range accesses
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 9) == 0) addr = $urandom;
      else addr = 32'($urandom_range(0, DEPTH * 4 - 1));
      size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      do_req("rand", 1'($urandom), size, 1'($urandom), addr, $urandom, rd, er);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
